sram_4096x76_arb: RTL and testbench

- Two-requester arbiter and sequencer for the 4096x76 bit-write-enable SRAM macro.
- Accepts at most one read or write per cycle, round-robin between port A (host) and port B (DMA).
- Drives the macro's active-low bit-enable bus and static margin pins; returns read data with fixed 1-cycle latency.
- Optionally zero-fills the whole array after reset before serving requests.

---
 rtl/sram_4096x76_arb.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_4096x76_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_4096x76_arb.sv
// sram_4096x76_arb
// Two-requester round-robin arbiter and sequencer for the 4096x76 bit-write-enable
// SRAM macro. At most one access is issued per cycle. Grants and macro drive are
// combinational in the cycle a request is seen, and the macro samples them on the
// next rising edge. Read data returns one cycle after the grant.
//
// Optional feature (macro SRAM_ARB_INIT_EN): when defined, the whole array is
// zero-filled after reset (INIT state), and init_done rises 4097 cycles after
// reset release. When undefined, the block goes straight to IDLE, init_done rises
// one cycle after reset release, and the array contents are undefined.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   a_* / b_*                    host / DMA request ports (req, we, addr, wdata,
//                                wmask) and responses (gnt, rvalid, rdata)
//   init_done                    array ready; requests are served only when 1
//   mem_ren/wen/adr/din/wbeb     macro access pins (wbeb active-low per bit)
//   mem_q                        macro read data
//   mem_mc/mcen/wa/wpulse/
//   wpulseen/clkbyp/fwen         static macro margin pins
module sram_4096x76_arb #(
   parameter logic [2:0] MC       = 3'b000,
   parameter logic       MCEN     = 1'b0,
   parameter logic [1:0] WA       = 2'b00,
   parameter logic [1:0] WPULSE   = 2'b00,
   parameter logic       WPULSEEN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [11:0] a_addr,
   input  logic [75:0] a_wdata,
   input  logic [75:0] a_wmask,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [75:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [11:0] b_addr,
   input  logic [75:0] b_wdata,
   input  logic [75:0] b_wmask,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [75:0] b_rdata,
   output logic        init_done,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [11:0] mem_adr,
   output logic [75:0] mem_din,
   output logic [75:0] mem_wbeb,
   input  logic [75:0] mem_q,
   output logic [2:0]  mem_mc,
   output logic        mem_mcen,
   output logic        mem_clkbyp,
   output logic [1:0]  mem_wa,
   output logic [1:0]  mem_wpulse,
   output logic        mem_wpulseen,
   output logic        mem_fwen
);

   localparam logic [75:0] ALL_ONES = {76{1'b1}};

   logic        prio_a_r;      // 1: port A wins the next contended cycle
   logic        init_done_r;
   logic        rd_a_r;        // response tag: read granted to A last cycle
   logic        rd_b_r;        // response tag: read granted to B last cycle
   logic [75:0] a_hold_r;
   logic [75:0] b_hold_r;
   logic        idle_s;
   logic        init_act_s;
   logic [11:0] init_adr_s;
   logic        a_win_s;
   logic        b_win_s;

`ifdef SRAM_ARB_INIT_EN
   typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;
   state_t      state_r;
   state_t      state_s;
   logic [11:0] cnt_r;
   logic [11:0] cnt_s;

   // State and zero-fill address counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_INIT;
         cnt_r   <= 12'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next state: sweep every address once, then stay in IDLE until reset
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_INIT: begin
            cnt_s = cnt_r + 12'd1;
            if (cnt_r == 12'd4095) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_IDLE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_INIT;
            cnt_s   = 12'd0;
         end
      endcase
   end

   // Zero-fill drive is held off while reset is asserted so the pins show reset values
   assign init_act_s = (state_r == ST_INIT) && !rst;
   assign init_adr_s = cnt_r;
   assign idle_s     = (state_r == ST_IDLE);
`else
   assign init_act_s = 1'b0;
   assign init_adr_s = 12'd0;
   assign idle_s     = 1'b1;
`endif

   // init_done trails entry into IDLE by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= idle_s;
      end
   end

   // Round-robin grant; init_done_r is already 0 during reset and INIT
   always_comb begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
      if (init_done_r) begin
         a_win_s = a_req && (!b_req || prio_a_r);
         b_win_s = b_req && (!a_req || !prio_a_r);
      end else begin
         a_win_s = 1'b0;
         b_win_s = 1'b0;
      end
   end

   // Priority pointer moves only when both ports contend
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_a_r <= 1'b1;
      end else if (init_done_r && a_req && b_req) begin
         prio_a_r <= !prio_a_r;
      end else begin
         prio_a_r <= prio_a_r;
      end
   end

   // Macro access drive for the current cycle
   always_comb begin
      mem_wen  = 1'b0;
      mem_ren  = 1'b0;
      mem_adr  = 12'd0;
      mem_din  = 76'd0;
      mem_wbeb = ALL_ONES;
      if (init_act_s) begin
         mem_wen  = 1'b1;
         mem_adr  = init_adr_s;
         mem_wbeb = 76'd0;
      end else if (a_win_s) begin
         mem_adr = a_addr;
         if (a_we) begin
            mem_wen  = 1'b1;
            mem_din  = a_wdata;
            mem_wbeb = ~a_wmask;
         end else begin
            mem_ren = 1'b1;
         end
      end else if (b_win_s) begin
         mem_adr = b_addr;
         if (b_we) begin
            mem_wen  = 1'b1;
            mem_din  = b_wdata;
            mem_wbeb = ~b_wmask;
         end else begin
            mem_ren = 1'b1;
         end
      end else begin
         mem_wen = 1'b0;
      end
   end

   // Response tags and read-data hold registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_a_r   <= 1'b0;
         rd_b_r   <= 1'b0;
         a_hold_r <= 76'd0;
         b_hold_r <= 76'd0;
      end else begin
         rd_a_r <= a_win_s && !a_we;
         rd_b_r <= b_win_s && !b_we;
         if (rd_a_r) begin
            a_hold_r <= mem_q;
         end else begin
            a_hold_r <= a_hold_r;
         end
         if (rd_b_r) begin
            b_hold_r <= mem_q;
         end else begin
            b_hold_r <= b_hold_r;
         end
      end
   end

   // mem_q is live in the response cycle, so rdata passes it through then and holds afterwards
   assign a_gnt        = a_win_s;
   assign b_gnt        = b_win_s;
   assign a_rvalid     = rd_a_r;
   assign b_rvalid     = rd_b_r;
   assign a_rdata      = rd_a_r ? mem_q : a_hold_r;
   assign b_rdata      = rd_b_r ? mem_q : b_hold_r;
   assign init_done    = init_done_r;
   assign mem_mc       = MC;
   assign mem_mcen     = MCEN;
   assign mem_wa       = WA;
   assign mem_wpulse   = WPULSE;
   assign mem_wpulseen = WPULSEEN;
   assign mem_clkbyp   = 1'b0;
   assign mem_fwen     = 1'b0;

endmodule

// File: tb/tb_sram_4096x76_arb.sv
// Testbench for sram_4096x76_arb: a behavioural SRAM macro, a reference model of
// arbitration, INIT sequencing and memory contents, directed scenarios and a
// randomized request phase.
module tb_sram_4096x76_arb;

   localparam logic [75:0] ONES = {76{1'b1}};
`ifdef SRAM_ARB_INIT_EN
   localparam int INIT_CYC = 4097;
`else
   localparam int INIT_CYC = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [11:0] a_addr = '0, b_addr = '0;
   logic [75:0] a_wdata = '0, a_wmask = '0, b_wdata = '0, b_wmask = '0;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
   logic [75:0] a_rdata, b_rdata;
   logic        mem_ren, mem_wen, mem_mcen, mem_clkbyp, mem_wpulseen, mem_fwen;
   logic [11:0] mem_adr;
   logic [75:0] mem_din, mem_wbeb;
   logic [75:0] mem_q = '0;
   logic [2:0]  mem_mc;
   logic [1:0]  mem_wa, mem_wpulse;

   always #5 clk = ~clk;

   sram_4096x76_arb dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wmask(a_wmask),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .init_done(init_done),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_adr(mem_adr), .mem_din(mem_din),
      .mem_wbeb(mem_wbeb), .mem_q(mem_q),
      .mem_mc(mem_mc), .mem_mcen(mem_mcen), .mem_clkbyp(mem_clkbyp), .mem_wa(mem_wa),
      .mem_wpulse(mem_wpulse), .mem_wpulseen(mem_wpulseen), .mem_fwen(mem_fwen)
   );

   // Behavioural macro: active-low bit enables, registered read data
   logic [75:0] mac [0:4095];
   always @(posedge clk) begin
      if (mem_wen) mac[mem_adr] <= (mac[mem_adr] & mem_wbeb) | (mem_din & ~mem_wbeb);
      if (mem_ren) mem_q <= mac[mem_adr];
   end

   // Reference model state
   logic [75:0] ref_mem [0:4095];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic        prio_a = 1'b1;
   logic        pend_a = 1'b0, pend_b = 1'b0;
   logic [75:0] pend_ad = '0, pend_bd = '0, exp_ard = '0, exp_brd = '0;
   logic        last_ag = 1'b0, last_bg = 1'b0;

   function automatic logic [75:0] pat(input int a);
      logic [31:0] av;
      av  = a;
      pat = {64'h5A5A_C3C3_0F0F_9696, av[11:0]};
   endfunction

   task automatic check_value(input string tag, input logic [75:0] got, input logic [75:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s (cyc %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle of reference checking; entered at posedge+1 with inputs set
   task automatic tick();
      logic        ex_done, init_ph, ex_ag, ex_bg, ex_wen, ex_ren;
      logic [11:0] ex_adr;
      logic [75:0] ex_din, ex_wbeb;
      @(negedge clk);
      init_ph = 1'b0;
`ifdef SRAM_ARB_INIT_EN
      init_ph = (cyc < 4096);
      ex_done = (cyc >= 4097);
`else
      ex_done = (cyc >= 1);
`endif
      check_value("init_done", init_done, ex_done);
      ex_ag = ex_done && a_req && (!b_req || prio_a);
      ex_bg = ex_done && b_req && (!a_req || !prio_a);
      check_value("a_gnt", a_gnt, ex_ag);
      check_value("b_gnt", b_gnt, ex_bg);
      if (pend_a) exp_ard = pend_ad;
      if (pend_b) exp_brd = pend_bd;
      check_value("a_rvalid", a_rvalid, pend_a);
      check_value("b_rvalid", b_rvalid, pend_b);
      check_value("a_rdata", a_rdata, exp_ard);
      check_value("b_rdata", b_rdata, exp_brd);
      ex_wen = 1'b0; ex_ren = 1'b0; ex_adr = '0; ex_din = '0; ex_wbeb = ONES;
      if (init_ph) begin
         ex_wen = 1'b1; ex_adr = cyc[11:0]; ex_wbeb = '0;
      end else if (ex_ag) begin
         ex_adr = a_addr; ex_wen = a_we; ex_ren = !a_we;
         if (a_we) begin ex_din = a_wdata; ex_wbeb = ~a_wmask; end
      end else if (ex_bg) begin
         ex_adr = b_addr; ex_wen = b_we; ex_ren = !b_we;
         if (b_we) begin ex_din = b_wdata; ex_wbeb = ~b_wmask; end
      end
      check_value("mem_wen", mem_wen, ex_wen);
      check_value("mem_ren", mem_ren, ex_ren);
      check_value("mem_wbeb", mem_wbeb, ex_wbeb);
      if (ex_wen || ex_ren) begin
         check_value("mem_adr", mem_adr, ex_adr);
         check_value("mem_din", mem_din, ex_din);
      end
      // Model update: contents, pending responses, pointer
      pend_a = 1'b0; pend_b = 1'b0;
      if (ex_ag && !a_we) begin pend_a = 1'b1; pend_ad = ref_mem[a_addr]; end
      if (ex_bg && !b_we) begin pend_b = 1'b1; pend_bd = ref_mem[b_addr]; end
      if (ex_ag && a_we) ref_mem[a_addr] = (ref_mem[a_addr] & ~a_wmask) | (a_wdata & a_wmask);
      if (ex_bg && b_we) ref_mem[b_addr] = (ref_mem[b_addr] & ~b_wmask) | (b_wdata & b_wmask);
      if (ex_done && a_req && b_req) prio_a = !prio_a;
      last_ag = ex_ag; last_bg = ex_bg;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      a_req = 1'b0; b_req = 1'b0;
      #1;
      check_value("rst_a_gnt", a_gnt, 1'b0);
      check_value("rst_b_gnt", b_gnt, 1'b0);
      check_value("rst_a_rvalid", a_rvalid, 1'b0);
      check_value("rst_b_rvalid", b_rvalid, 1'b0);
      check_value("rst_a_rdata", a_rdata, 76'h0);
      check_value("rst_b_rdata", b_rdata, 76'h0);
      check_value("rst_mem_ren", mem_ren, 1'b0);
      check_value("rst_mem_wen", mem_wen, 1'b0);
      check_value("rst_mem_wbeb", mem_wbeb, ONES);
      check_value("rst_mem_adr", mem_adr, 12'h0);
      check_value("rst_mem_din", mem_din, 76'h0);
      check_value("rst_init_done", init_done, 1'b0);
      repeat (hold) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0; prio_a = 1'b1; pend_a = 1'b0; pend_b = 1'b0;
      exp_ard = '0; exp_brd = '0; last_ag = 1'b0; last_bg = 1'b0;
`ifdef SRAM_ARB_INIT_EN
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
`endif
   endtask

   initial begin
      logic [95:0] r96;
      logic [75:0] m4;
      int          r;
      for (int i = 0; i < 4096; i++) begin
         mac[i] <= pat(i);
         ref_mem[i] = pat(i);
      end
      do_reset(3);
      check_value("static_mc", {mem_mc, mem_mcen, mem_wa, mem_wpulse, mem_wpulseen, mem_clkbyp, mem_fwen}, 11'h0);
`ifdef SRAM_ARB_INIT_EN
      // Interrupt INIT at address 1000; the sweep must restart at 0
      repeat (1000) tick();
      check_value("init_adr_1000", mem_adr, 12'd1000);
      do_reset(2);
`endif
      // Read of 0x7FF held during INIT, served only once init_done is up
      a_req = 1'b1; a_we = 1'b0; a_addr = 12'h7FF;
      repeat (INIT_CYC) tick();
      tick();
      check_value("init_rd_rvalid", a_rvalid, 1'b1);
`ifdef SRAM_ARB_INIT_EN
      check_value("init_rd_zero", a_rdata, 76'h0);
`endif
      a_req = 1'b0;
      // Full write then read-after-write at 0x123
      a_req = 1'b1; a_we = 1'b1; a_addr = 12'h123; a_wdata = ONES; a_wmask = ONES;
      tick();
      a_we = 1'b0;
      tick();
      check_value("raw_rvalid", a_rvalid, 1'b1);
      check_value("raw_rdata", a_rdata, ONES);
      // Partial write of low 4 bits over all-ones contents
      a_we = 1'b1; a_addr = 12'h010; a_wdata = ONES; a_wmask = ONES;
      tick();
      m4 = 76'hF;
      a_wdata = '0; a_wmask = m4;
      #1;
      check_value("pw_wbeb", mem_wbeb, ~m4);
      tick();
      a_we = 1'b0;
      tick();
      check_value("pw_rdata", a_rdata, ~m4);
      a_req = 1'b0;
      // Contended reads: expect A,B,A,B with rvalid following one cycle later
      a_we = 1'b1; a_wmask = ONES;
      for (int i = 0; i < 4; i++) begin
         a_req = 1'b1; a_addr = 12'h020 + 12'(i); a_wdata = ONES ^ pat(32 + i);
         tick();
      end
      a_we = 1'b0; a_addr = 12'h020; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h021;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_value("rr_a_gnt", a_gnt, (i % 2 == 0));
         check_value("rr_b_gnt", b_gnt, (i % 2 == 1));
         tick();
         check_value("rr_a_rvalid", a_rvalid, (i % 2 == 0));
         check_value("rr_b_rvalid", b_rvalid, (i % 2 == 1));
         if (i == 0) a_addr = 12'h022;
         if (i == 1) b_addr = 12'h023;
         if (i == 2) a_addr = 12'h020;
      end
      a_req = 1'b0; b_req = 1'b0;
      tick();
      // Randomized traffic on a small address window to provoke read-after-write hits
      for (int n = 0; n < 2000; n++) begin
         if (!a_req || last_ag) begin
            a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
            a_addr = 12'($urandom_range(0, 15));
            r96 = {$urandom, $urandom, $urandom}; a_wdata = r96[75:0];
            r = $urandom_range(0, 3); r96 = {$urandom, $urandom, $urandom};
            a_wmask = (r == 0) ? ONES : (r == 1) ? 76'h0 : r96[75:0];
         end
         if (!b_req || last_bg) begin
            b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1);
            b_addr = 12'($urandom_range(0, 15));
            r96 = {$urandom, $urandom, $urandom}; b_wdata = r96[75:0];
            r = $urandom_range(0, 3); r96 = {$urandom, $urandom, $urandom};
            b_wmask = (r == 0) ? ONES : (r == 1) ? 76'h0 : r96[75:0];
         end
         tick();
      end
      // Reset in the cycle after a B read grant: no late response may appear
      a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h021;
      tick();
      b_req = 1'b0;
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_value("rst_drop_b_rvalid", b_rvalid, 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
